pipe_fetch_stage: RTL
=====================

Name: pipe_fetch_stage

Overview:
- IF stage of the 5-stage pipelined CPU, plus the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory read address.
- Applies stalls from the hazard unit, branch redirects from EX, and jump redirects from ID.
- Delivers {instr, pc+4, valid} to the decode stage.
- Stops fetching when a `syscall` reaches IF/ID, so system benches can detect halt and check the register file after the program ends.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- HALT_INSTR, 32'h0000_000C, encoding that halts fetch (MIPS `syscall`).
- NOP_INSTR, 32'h0000_0000, value driven on id_instr for bubbles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory, equal to pc.
- imem_rdata  in  32  instruction at imem_addr; combinational, same cycle.
- stall  in  1  hazard unit holds PC and IF/ID.
- ex_redirect  in  1  taken branch resolved in EX.
- ex_target  in  32  branch target.
- id_jump  in  1  j/jal/jr decoded in ID.
- id_target  in  32  jump target.
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID pc+4.
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch has stopped on HALT_INSTR.
- fetch_count  out  32  instructions accepted into IF/ID.
- flush_count  out  32  IF/ID squashes.

Behaviour:
- Reset (async, while rst_n=0):
  - pc=RESET_PC; id_instr=NOP_INSTR; id_pc4=0; id_valid=0; halted=0; both counters=0.
  - FSM=BOOT.
- FSM states BOOT, RUN, HALT:
  - BOOT lasts one cycle, emits a bubble, does not advance pc, then goes to RUN. This guarantees imem setup after reset release.
  - RUN fetches normally.
  - HALT: pc frozen; IF/ID loads a bubble every cycle; halted=1. Exit only via reset. ex_redirect is still honoured as a squash (see the priority rules).
- Next-state priority in RUN, evaluated each rising edge; the highest applicable rule wins:
  1. ex_redirect=1:
     - pc <= {ex_target[31:2],2'b00}.
     - IF/ID <= bubble; flush_count += 1.
     - Overrides stall and id_jump in the same cycle; the instruction in ID is wrong-path.
  2. stall=1: pc and IF/ID hold, counters unchanged. id_jump is ignored, because the stalled ID re-presents it next cycle.
  3. id_jump=1:
     - pc <= {id_target[31:2],2'b00}.
     - IF/ID <= bubble; flush_count += 1.
     - There are no delay slots: the instruction fetched this cycle is squashed.
  4. Otherwise:
     - pc <= pc+4.
     - id_instr <= imem_rdata; id_pc4 <= pc+4; id_valid <= 1; fetch_count += 1.
     - If imem_rdata == HALT_INSTR, FSM goes to HALT on the same edge. The syscall itself enters IF/ID with valid=1, and halted rises on that edge.
- Bubble: id_instr=NOP_INSTR, id_pc4=0, id_valid=0.
- ex_redirect in HALT: FSM returns to RUN at the target, counted as a flush. This covers a wrong-path syscall fetched behind a taken branch.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000) with no error.
  - Counters saturate at 0xFFFF_FFFF.
- imem_addr = pc combinationally; no other output depends combinationally on inputs.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk; BOOT is re-entered on release.

Test Plan:
1. Straight-line fetch:
   - Stimulus: reset, then memory {0x20080001, 0x20090002, 0x0000000C} at 0, 4, 8.
   - Response: id_valid=0 in the BOOT cycle, then instrs appear on consecutive cycles with id_pc4=4, 8, 0xC.
   - halted=1 after the edge that loads 0x0000000C; fetch_count=3; pc frozen at 0xC.
2. Stall hold: stall=1 for 3 cycles while pc=0x8 → id_instr/id_pc4/pc unchanged for those cycles; fetch_count unchanged; resumes at 0x8.
3. EX redirect beats stall and jump:
   - Stimulus: same cycle ex_redirect=1, ex_target=0x40, stall=1, id_jump=1, id_target=0x80.
   - Response: next pc=0x40, IF/ID bubble, flush_count+1.
4. ID jump: id_jump=1, id_target=0x103 → pc=0x100 (low bits cleared); IF/ID bubble; next valid instr has id_pc4=0x104.
5. Wrong-path halt:
   - Stimulus: syscall fetched, halted=1, then ex_redirect=1, target 0x20 next cycle.
   - Response: halted=0, RUN at pc=0x20, flush_count+1.
6. Async reset and wrap:
   - Wrap: RESET_PC=0xFFFF_FFFC, imem returns 0x20080001 at every address → id_pc4=0x0, next pc=0x0.
   - Async reset: drop rst_n between clock edges → outputs at reset values before the next edge.

Source files
------------

// File: rtl/pipe_fetch_stage.sv
// IF stage with IF/ID pipeline register: owns the PC, applies redirects and stalls,
// and stops fetching once a syscall has been latched into IF/ID.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_jump,
  input  logic [31:0] id_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] pc_plus4;
  logic [31:0] ex_target_aligned;
  logic [31:0] id_target_aligned;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Wraps modulo 2^32 by construction.
  assign pc_plus4          = pc_q + 32'd4;
  assign ex_target_aligned = ex_target & ~32'd3;
  assign id_target_aligned = id_target & ~32'd3;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;

    unique case (state_q)
      StBoot: begin
        id_instr_d = NOP_INSTR;
        id_pc4_d   = 32'd0;
        id_valid_d = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        if (ex_redirect) begin
          pc_d          = ex_target_aligned;
          id_instr_d    = NOP_INSTR;
          id_pc4_d      = 32'd0;
          id_valid_d    = 1'b0;
          flush_count_d = sat_inc(flush_count_q);
        end else if (stall) begin
          // Stalled ID re-presents any jump next cycle, so it is ignored here.
          pc_d = pc_q;
        end else if (id_jump) begin
          pc_d          = id_target_aligned;
          id_instr_d    = NOP_INSTR;
          id_pc4_d      = 32'd0;
          id_valid_d    = 1'b0;
          flush_count_d = sat_inc(flush_count_q);
        end else begin
          pc_d          = pc_plus4;
          id_instr_d    = imem_rdata;
          id_pc4_d      = pc_plus4;
          id_valid_d    = 1'b1;
          fetch_count_d = sat_inc(fetch_count_q);
          if (imem_rdata == HALT_INSTR) begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        id_instr_d = NOP_INSTR;
        id_pc4_d   = 32'd0;
        id_valid_d = 1'b0;
        // A syscall fetched behind a taken branch is wrong-path: resume at the target.
        if (ex_redirect) begin
          pc_d          = ex_target_aligned;
          flush_count_d = sat_inc(flush_count_q);
          state_d       = StRun;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc4_q      <= 32'd0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc4      = id_pc4_q;
  assign id_valid    = id_valid_q;
  assign halted      = (state_q == StHalt);
  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;

endmodule
